// File: rtl/sweep_ctrl.sv
// Frequency-sweep controller: steps the address counter's increment from a start
// to a stop value, holding each tone for a programmable dwell, single-shot or looping.
module sweep_ctrl #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned DWELL_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic               loop,
   input  logic [WIDTH-1:0]   f_start,
   input  logic [WIDTH-1:0]   f_stop,
   input  logic [WIDTH-1:0]   f_step,
   input  logic [DWELL_W-1:0] dwell,
   output logic               count_en,
   output logic [WIDTH-1:0]   count_incr,
   output logic               busy,
   output logic               tone_tick,
   output logic               done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state, state_d;

   logic               loop_q;
   logic [WIDTH-1:0]   fstart_q, fstop_q, fstep_q;
   logic [DWELL_W-1:0] dwell_q;
   logic [DWELL_W-1:0] dwell_cnt, dwell_cnt_d;

   logic               accept, advance, wrap;
   logic               last_cycle, end_sweep;
   logic [WIDTH:0]     next_sum;
   logic [DWELL_W-1:0] dwell_eff;

   logic               count_en_d, busy_d, tone_tick_d, done_d;
   logic [WIDTH-1:0]   count_incr_d;

   assign dwell_eff  = (dwell == '0) ? DWELL_W'(1) : dwell;
   assign last_cycle = (dwell_cnt == DWELL_W'(1));
   // One extra bit so a step past the top of the range never wraps to a low tone
   assign next_sum   = {1'b0, count_incr} + {1'b0, fstep_q};
   assign end_sweep  = (fstep_q == '0) || (next_sum > {1'b0, fstop_q}) || (fstart_q > fstop_q);

   // State, latched configuration and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         loop_q     <= 1'b0;
         fstart_q   <= '0;
         fstop_q    <= '0;
         fstep_q    <= '0;
         dwell_q    <= '0;
         dwell_cnt  <= '0;
         count_en   <= 1'b0;
         count_incr <= '0;
         busy       <= 1'b0;
         tone_tick  <= 1'b0;
         done       <= 1'b0;
      end else begin
         state     <= state_d;
         dwell_cnt <= dwell_cnt_d;
         if (accept) begin
            loop_q   <= loop;
            fstart_q <= f_start;
            fstop_q  <= f_stop;
            fstep_q  <= f_step;
            dwell_q  <= dwell_eff;
         end
         count_en   <= count_en_d;
         count_incr <= count_incr_d;
         busy       <= busy_d;
         tone_tick  <= tone_tick_d;
         done       <= done_d;
      end
   end

   // Next-state and dwell counter
   always_comb begin
      state_d     = state;
      accept      = 1'b0;
      advance     = 1'b0;
      wrap        = 1'b0;
      dwell_cnt_d = '0;
      case (state)
         S_IDLE: begin
            if (start && !abort) begin
               accept      = 1'b1;
               state_d     = S_RUN;
               dwell_cnt_d = dwell_eff;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (last_cycle) begin
               if (!end_sweep) begin
                  advance     = 1'b1;
                  dwell_cnt_d = dwell_q;
               end else if (loop_q) begin
                  wrap        = 1'b1;
                  dwell_cnt_d = dwell_q;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               dwell_cnt_d = dwell_cnt - DWELL_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output values for the next cycle
   always_comb begin
      count_en_d   = (state_d == S_RUN);
      busy_d       = (state_d == S_RUN);
      done_d       = (state_d == S_DONE);
      tone_tick_d  = accept || advance || wrap;
      count_incr_d = '0;
      if (accept)
         count_incr_d = f_start;
      else if (advance)
         count_incr_d = next_sum[WIDTH-1:0];
      else if (wrap)
         count_incr_d = fstart_q;
      else if (state_d == S_RUN)
         count_incr_d = count_incr;
   end

endmodule

// File: doc/sweep_ctrl.md
# sweep_ctrl

Frequency-sweep controller for the signal generator's address counter. Drives the counter's `en` and `incr` inputs to step the counter increment (tone frequency) from a start value to a stop value. Each tone is held for a programmable number of clock cycles. Sits between the configuration/top-level logic and the counter that addresses the waveform ROM. Supports single-shot and continuous (looping) sweeps, with a start/busy/done handshake and abort.

## Interface
Parameters:
- `WIDTH`, default 8, width of counter increment and frequency values (matches counter `WIDTH`).
- `DWELL_W`, default 16, width of the dwell-length field.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin sweep; sampled only in IDLE.
- `abort`  in  1  stop sweep immediately; highest priority after `rst`.
- `loop`  in  1  0 = single sweep, 1 = restart from `f_start` after last tone; latched at start.
- `f_start`  in  WIDTH  first increment value; latched at start.
- `f_stop`  in  WIDTH  upper bound on increment value; latched at start.
- `f_step`  in  WIDTH  increment added between tones; latched at start.
- `dwell`  in  DWELL_W  cycles per tone; 0 is treated as 1; latched at start.
- `count_en`  out  1  to counter `en`.
- `count_incr`  out  WIDTH  to counter `incr`.
- `busy`  out  1  high while sweeping.
- `tone_tick`  out  1  one-cycle pulse on the first cycle of every tone, including the first.
- `done`  out  1  one-cycle pulse when a single sweep completes normally.

## Operation
- States: IDLE, RUN, DONE.
- Reset, and whenever not in RUN: `count_en`=0, `count_incr`=0, `busy`=0, `tone_tick`=0. `done`=0 except in DONE.
- IDLE:
  - `start`=1 and `abort`=0 → latch config, load `count_incr`=f_start, load dwell counter = max(dwell,1), go RUN.
  - `start` and `abort` together → stay IDLE.
- RUN:
  - `count_en`=1, `busy`=1; dwell counter decrements each cycle.
  - On the last dwell cycle, compute `next = count_incr + f_step` at WIDTH+1 bits (no wrap).
  - End-of-sweep condition: `f_step`==0, or `next` > `f_stop`, or latched `f_start` > `f_stop`.
  - Not end → `count_incr`=next[WIDTH-1:0], reload dwell, pulse `tone_tick`.
  - End with `loop`=1 → `count_incr`=f_start, reload dwell, pulse `tone_tick`.
  - End with `loop`=0 → go DONE.
- DONE: `done`=1, everything else 0; go IDLE next cycle. `start` is ignored in DONE.
- `abort`=1 in RUN or DONE → IDLE next cycle, no `done` pulse.
- `start` while `busy` is ignored. Input config changes mid-sweep have no effect.
- Tone count for a single sweep: N = floor((f_stop−f_start)/f_step)+1 when f_start ≤ f_stop and f_step > 0; otherwise N = 1.

## Timing
- `start` sampled at edge T → from cycle T+1: `busy`=1, `count_en`=1, `count_incr`=f_start, `tone_tick`=1.
- Each tone presents `count_en`=1 for exactly D = max(dwell,1) consecutive cycles. There is no gap between tones and no gap on loop wrap.
- Single sweep: `busy` lasts N·D cycles; `done` is high at cycle T+1+N·D with `busy`=0. The earliest next `start` is accepted at the following edge.
- `abort` sampled at edge A → `count_en`=0 and `busy`=0 from cycle A+1.
- `rst` has the same effect as `abort` and also clears the latched config. It takes effect at the next edge in any state.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- WIDTH=8, start=10, stop=30, step=10, dwell=4, loop=0 → `count_incr` 10×4, 20×4, 30×4 cycles; `tone_tick` at cycles 1,5,9; `done` at cycle 13; `busy` high for exactly 12 cycles.
- start=250, stop=255, step=4, dwell=1 → tones 250, 254 only; no wrap to low values; `done` at cycle 3.
- loop=1, start=1, stop=3, step=1, dwell=2 → sequence 1,1,2,2,3,3,1,1,2,2; `abort` at cycle 10 → `count_en`=0 at cycle 11, no `done`.
- dwell=0, step=0, start=7 → a single tone of 7 for 1 cycle, then `done`. Separately, start=40 > stop=20 → tone 40 for D cycles, then `done`.
- Pulse `start` again mid-sweep and change f_start/dwell mid-sweep → sweep unaffected. `start`+`abort` together in IDLE → stays IDLE.
- Assert `rst` for 1 cycle mid-RUN → next cycle all outputs 0, state IDLE. A new `start` then runs a full sweep with freshly latched config.
